// File: rtl/image_encoder.sv
// image_encoder: captures a 64-bit 8x8 binary image and streams it out as indexed row slices over valid/ready
module image_encoder #(
  parameter int SLICE_W    = 8,
  parameter int NUM_SLICES = 8,
  parameter int SEL_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load_i,
  input  logic [SLICE_W*NUM_SLICES-1:0] image_i,
  input  logic                          ready_i,
  output logic [SLICE_W-1:0]            slice_o,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          valid_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          done_o
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SLICES - 1);
  state_t                          state;
  logic [SLICE_W*NUM_SLICES-1:0]   img;
  logic [SEL_W-1:0]                nxt;
  logic                            xfer;
  logic                            cap;
  assign nxt  = sel_o + 1'b1;
  // en gates the handshake so a frozen slice is re-presented rather than consumed
  assign xfer = valid_o && ready_i && en;
  assign cap  = load_i && en && state != SEND;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      img     <= '0;
      slice_o <= '0;
      sel_o   <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else if (cap) begin
      state   <= SEND;
      img     <= image_i;
      slice_o <= image_i[SLICE_W-1:0];
      sel_o   <= '0;
      valid_o <= 1'b1;
      last_o  <= NUM_SLICES == 1;
      busy_o  <= 1'b1;
      done_o  <= 1'b0;
    end else if (state == SEND) begin
      if (xfer && sel_o == LAST) begin
        state   <= DONE;
        valid_o <= 1'b0;
        last_o  <= 1'b0;
        busy_o  <= 1'b0;
        done_o  <= 1'b1;
      end else begin
        if (xfer) begin
          sel_o   <= nxt;
          slice_o <= img[int'(nxt)*SLICE_W +: SLICE_W];
        end
        valid_o <= en;
        last_o  <= en && (xfer ? nxt : sel_o) == LAST;
      end
    end else begin
      state   <= IDLE;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_image_encoder.sv
// tb_image_encoder: directed and randomized streaming checks against a slice-order reference model
module tb_image_encoder;
  logic        clk = 0;
  logic        rst = 1;
  logic        en = 0;
  logic        load_i = 0;
  logic [63:0] image_i = '0;
  logic        ready_i = 0;
  logic [7:0]  slice_o;
  logic [2:0]  sel_o;
  logic        valid_o, last_o, busy_o, done_o;
  int          checks = 0;
  int          errors = 0;

  image_encoder dut (
    .clk(clk), .rst(rst), .en(en), .load_i(load_i), .image_i(image_i), .ready_i(ready_i),
    .slice_o(slice_o), .sel_o(sel_o), .valid_o(valid_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_slice"}, slice_o, 0);
    chk({tag, "_sel"}, sel_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // Streams one image; the expected slice k is simply byte k of the image, and accepted slices are
  // reassembled into a rebuilt image to mirror a downstream decoder.
  task automatic xfer(input logic [63:0] img, input bit rnd, input bit stall, input bit freeze,
                      input bit junk, input bit preload, input bit chain, input logic [63:0] nxt_img);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    int frz = 0;
    bit froze = 0;
    logic [63:0] rebuilt = '0;
    if (!preload) begin
      @(negedge clk);
      image_i = img; load_i = 1; en = 1; ready_i = 1;
    end
    @(negedge clk);
    load_i = 0;
    while (k < 8 && cyc < 200) begin
      cyc++;
      if (frz > 0) begin
        chk("frozen_valid", valid_o, 0);
        chk("frozen_busy", busy_o, 1);
        frz--;
        en = (frz == 0);
        ready_i = 0;
      end else begin
        chk("valid", valid_o, 1);
        chk("sel", sel_o, k);
        chk("slice", slice_o, (img >> (8 * k)) & 64'hFF);
        chk("last", last_o, k == 7);
        chk("busy", busy_o, 1);
        chk("done", done_o, 0);
        load_i = junk && k == 1;
        image_i = load_i ? '1 : img;
        if (freeze && k == 4 && !froze) begin
          en = 0; ready_i = 0; frz = 2; froze = 1;
        end else if (stall && k == 2 && stalls < 3) begin
          ready_i = 0; stalls++;
        end else ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ready_i && en) begin
          rebuilt |= 64'(slice_o) << (8 * sel_o);
          k++;
        end
      end
      @(negedge clk);
    end
    load_i = 0;
    chk("timeout_slices", k, 8);
    chk("done_pulse", done_o, 1);
    chk("done_valid", valid_o, 0);
    chk("done_busy", busy_o, 0);
    chk("done_last", last_o, 0);
    chk("loopback", rebuilt, img);
    load_i = chain;
    image_i = nxt_img;
    ready_i = 1;
    if (!chain) begin
      @(negedge clk);
      chk("idle_valid", valid_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
    end
  endtask

  initial begin
    #2 rst = 0;
    #1 chk_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    en = 1;
    for (int i = 0; i < 20; i++) begin
      ready_i = 1'($urandom);
      @(negedge clk);
      chk("idle_hold_valid", valid_o, 0);
      chk("idle_hold_busy", busy_o, 0);
    end
    xfer(64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, 0, '0);
    xfer(64'h0123_4567_89AB_CDEF, 0, 1, 0, 0, 0, 0, '0);
    xfer(64'h0123_4567_89AB_CDEF, 0, 0, 1, 1, 0, 0, '0);
    xfer({$urandom, $urandom}, 1, 0, 0, 0, 0, 1, 64'hFF00_FF00_FF00_FF00);
    xfer(64'hFF00_FF00_FF00_FF00, 0, 0, 0, 0, 1, 0, '0);
    xfer(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0, '0);
    xfer(64'h8142_2418_1824_4281, 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) xfer({$urandom, $urandom}, 1, 1, 1, 1, 0, 0, '0);
    @(negedge clk);
    image_i = 64'h0123_4567_89AB_CDEF; load_i = 1; en = 1; ready_i = 1;
    @(negedge clk);
    load_i = 0;
    repeat (5) @(negedge clk);
    chk("pre_reset_sel", sel_o, 5);
    chk("pre_reset_slice", slice_o, 8'h45);
    @(posedge clk);
    #2 rst = 0;
    #1 chk_zero("reset_mid");
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_valid", valid_o, 0);
      chk("post_reset_busy", busy_o, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
